// File: rtl/io_bank_arbiter_pkg.sv
// Shared FSM encodings and width helpers for the IO bank arbiter family.
// Optional lock feature is selected elsewhere with IO_ARB_LOCK_EN.
package io_bank_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_GRANT = 2'd1;
    localparam arb_state_t ST_TURN  = 2'd2;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_bank_arbiter_if.sv
// Requester/pad bundle between sub-projects and the IO bank arbiter.
// lock_i exists only when IO_ARB_LOCK_EN is defined.
interface io_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 38
);
    import io_bank_arbiter_pkg::*;

    localparam int OWNER_W = owner_w(NREQ);

    logic [NREQ-1:0]       req_i;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ*WIDTH-1:0] lane_out_i;
    logic [NREQ*WIDTH-1:0] lane_oeb_i;
    logic [WIDTH-1:0]      io_out;
    logic [WIDTH-1:0]      io_oeb;
    logic [OWNER_W-1:0]    owner_o;
    logic                  busy_o;
    logic                  preempt_o;
`ifdef IO_ARB_LOCK_EN
    logic                  lock_i;
`endif

    modport slave (
`ifdef IO_ARB_LOCK_EN
        input  lock_i,
`endif
        input  req_i, lane_out_i, lane_oeb_i,
        output gnt_o, io_out, io_oeb, owner_o, busy_o, preempt_o
    );

    modport master (
`ifdef IO_ARB_LOCK_EN
        output lock_i,
`endif
        output req_i, lane_out_i, lane_oeb_i,
        input  gnt_o, io_out, io_oeb, owner_o, busy_o, preempt_o
    );

endinterface

// File: rtl/io_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
// Shared by the arbiter family; independent of IO_ARB_LOCK_EN.
module rr_pick
    import io_bank_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int OWNER_W = owner_w(NREQ)
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] ptr,
    output logic               valid,
    output logic [OWNER_W-1:0] idx
);

    function automatic logic [OWNER_W-1:0] wrap_add(input logic [OWNER_W-1:0] a, input int b);
        logic [OWNER_W:0] s;
        s = {1'b0, a} + (OWNER_W+1)'(b);
        if (s >= (OWNER_W+1)'(NREQ)) s = s - (OWNER_W+1)'(NREQ);
        return s[OWNER_W-1:0];
    endfunction

    // Scan farthest-first so the nearest candidate to ptr is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                valid = 1'b1;
                idx   = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/io_bank_arbiter.sv
// Shares one IO pad bank among NREQ requesters: round-robin, bounded hold, tri-state turnaround.
// Define IO_ARB_LOCK_EN to add lock_i, which freezes the hold timer during GRANT.
module io_bank_arbiter
    import io_bank_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 38,
    parameter int MAX_HOLD = 1024,
    parameter int TURN_CYC = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    io_bank_arbiter_if.slave bus
);

    localparam int OWNER_W = owner_w(NREQ);
    localparam int HOLD_W  = owner_w(MAX_HOLD);
    localparam int TURN_W  = owner_w(TURN_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    arb_state_t          r_state;
    logic [OWNER_W-1:0]  r_ptr;
    logic [OWNER_W-1:0]  r_owner;
    logic [HOLD_W-1:0]   r_hold;
    logic [TURN_W-1:0]   r_turn;
    logic [NREQ-1:0]     r_gnt;
    logic [WIDTH-1:0]    r_io_out;
    logic [WIDTH-1:0]    r_io_oeb;
    logic                r_preempt;

    logic [NREQ-1:0][WIDTH-1:0] w_lane_out;
    logic [NREQ-1:0][WIDTH-1:0] w_lane_oeb;
    logic                       w_pick_vld;
    logic [OWNER_W-1:0]         w_pick_idx;
    logic [OWNER_W-1:0]         w_ptr_nxt;
    logic                       w_lock;
    logic                       w_release;
    logic                       w_others;
    logic                       w_timeout;
    logic                       w_exit;

    assign w_lane_out = bus.lane_out_i;
    assign w_lane_oeb = bus.lane_oeb_i;

`ifdef IO_ARB_LOCK_EN
    assign w_lock = bus.lock_i;
`else
    assign w_lock = 1'b0;
`endif

    rr_pick #(.NREQ(NREQ), .OWNER_W(OWNER_W)) u_pick (
        .req   (bus.req_i),
        .ptr   (r_ptr),
        .valid (w_pick_vld),
        .idx   (w_pick_idx)
    );

    // r_gnt is the owner's one-hot while in GRANT, so masking it leaves the waiters.
    assign w_release = ~bus.req_i[r_owner];
    assign w_others  = |(bus.req_i & ~r_gnt);
    assign w_timeout = (MAX_HOLD != 0) && (r_hold == HOLD_LAST) && w_others && !w_lock;
    assign w_exit    = (r_state == ST_GRANT) && (w_release || w_timeout);
    assign w_ptr_nxt = (r_owner == OWNER_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_hold    <= '0;
            r_turn    <= '0;
            r_gnt     <= '0;
            r_io_out  <= '0;
            r_io_oeb  <= '1;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_state  <= ST_GRANT;
                        r_owner  <= w_pick_idx;
                        r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        r_hold   <= '0;
                        r_io_out <= w_lane_out[w_pick_idx];
                        r_io_oeb <= w_lane_oeb[w_pick_idx];
                    end
                end
                ST_GRANT: begin
                    if (w_exit) begin
                        r_state   <= (TURN_CYC == 0) ? ST_IDLE : ST_TURN;
                        r_gnt     <= '0;
                        r_io_out  <= '0;
                        r_io_oeb  <= '1;
                        r_ptr     <= w_ptr_nxt;
                        r_hold    <= '0;
                        r_turn    <= TURN_LAST;
                        // A release in the timeout cycle wins: no preempt pulse.
                        r_preempt <= !w_release;
                    end else begin
                        r_io_out <= w_lane_out[r_owner];
                        r_io_oeb <= w_lane_oeb[r_owner];
                        if (!w_lock && (r_hold != HOLD_LAST)) r_hold <= r_hold + 1'b1;
                    end
                end
                ST_TURN: begin
                    if (r_turn == '0) r_state <= ST_IDLE;
                    else              r_turn  <= r_turn - 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt_o     = r_gnt;
    assign bus.io_out    = r_io_out;
    assign bus.io_oeb    = r_io_oeb;
    assign bus.owner_o   = r_owner;
    assign bus.busy_o    = (r_state != ST_IDLE);
    assign bus.preempt_o = r_preempt;

endmodule

// File: tb/tb_io_bank_arbiter.sv
// Self-checking bench for io_bank_arbiter: cycle model plus directed literal checks.
// Lock scenario is exercised only when IO_ARB_LOCK_EN is defined.
module tb_io_bank_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 8;
    localparam int TURN_CYC = 2;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b0;
    bit   lock     = 1'b0;
    bit   wiggle   = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    io_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef IO_ARB_LOCK_EN
    assign bus.lock_i = lock;
`endif

    io_bank_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    // Behavioural model: who owns the bank, how long they held it, turnaround left.
    typedef struct {
        bit               granted;
        int               owner;
        int               ptr;
        int               hold;
        int               turn;
        bit               preempt;
        logic [WIDTH-1:0] out;
        logic [WIDTH-1:0] oeb;
    } model_t;

    model_t m;

    function automatic logic [WIDTH-1:0] lane(input logic [NREQ*WIDTH-1:0] v, input int k);
        logic [NREQ*WIDTH-1:0] t;
        t = v >> (k * WIDTH);
        return t[WIDTH-1:0];
    endfunction

    function automatic model_t m_reset();
        model_t n;
        n.granted = 0; n.owner = 0; n.ptr = 0; n.hold = 0; n.turn = 0;
        n.preempt = 0; n.out = '0; n.oeb = '1;
        return n;
    endfunction

    function automatic model_t m_step(input model_t s, input logic [NREQ-1:0] req,
                                      input logic [NREQ*WIDTH-1:0] lo,
                                      input logic [NREQ*WIDTH-1:0] lb, input bit lk);
        model_t n;
        bit rel, waiting, tout;
        n = s;
        n.preempt = 0;
        if (s.granted) begin
            rel     = !req[s.owner];
            waiting = 0;
            for (int i = 0; i < NREQ; i++) if (i != s.owner && req[i]) waiting = 1;
            tout = (MAX_HOLD != 0) && (s.hold >= MAX_HOLD - 1) && waiting && !lk;
            if (rel || tout) begin
                n.granted = 0;
                n.preempt = !rel;
                n.ptr     = (s.owner + 1) % NREQ;
                n.hold    = 0;
                n.turn    = TURN_CYC;
                n.out     = '0;
                n.oeb     = '1;
            end else begin
                n.out = lane(lo, s.owner);
                n.oeb = lane(lb, s.owner);
                if (!lk && s.hold < MAX_HOLD - 1) n.hold = s.hold + 1;
            end
        end else if (s.turn > 0) begin
            n.turn = s.turn - 1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (s.ptr + i) % NREQ;
                if (!n.granted && req[k]) begin
                    n.granted = 1;
                    n.owner   = k;
                    n.hold    = 0;
                    n.out     = lane(lo, k);
                    n.oeb     = lane(lb, k);
                end
            end
        end
        return n;
    endfunction

    always @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) m <= m_reset();
        else           m <= m_step(m, bus.req_i, bus.lane_out_i, bus.lane_oeb_i, lock);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            chk("model gnt",     64'(bus.gnt_o),     m.granted ? (64'd1 << m.owner) : 64'd0);
            chk("model owner",   64'(bus.owner_o),   64'(m.owner));
            chk("model busy",    64'(bus.busy_o),    64'(m.granted || m.turn > 0));
            chk("model preempt", 64'(bus.preempt_o), 64'(m.preempt));
            chk("model io_out",  64'(bus.io_out),    64'(m.out));
            chk("model io_oeb",  64'(bus.io_oeb),    64'(m.oeb));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge wb_clk_i);
            if (wiggle)
                for (int k = 0; k < NREQ; k++) begin
                    bus.lane_out_i[k*WIDTH +: WIDTH] = WIDTH'($urandom);
                    bus.lane_oeb_i[k*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
        end
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        bus.req_i = '0;
        lock = 1'b0;
        tick(2);
        wb_rst_i = 1'b1;
    endtask

    task automatic wait_gnt(input string nm, input int lim);
        int n;
        n = 0;
        while (bus.gnt_o == '0 && n < lim) begin
            tick(1);
            n++;
        end
        if (bus.gnt_o == '0) begin
            checks++;
            errors++;
            $display("FAIL %s: no grant within %0d cycles", nm, lim);
        end
    endtask

    int order[5];
    int glen[5];
    int gap[5];
    int ng, cur_len, cur_gap, npre;
    logic [NREQ-1:0] prev;

    initial begin
        bus.req_i      = '0;
        bus.lane_out_i = '0;
        bus.lane_oeb_i = '1;
        tick(3);
        wb_rst_i = 1'b1;
        tick(1);
        chk("reset gnt",     64'(bus.gnt_o),     64'h0);
        chk("reset io_oeb",  64'(bus.io_oeb),    64'hFF);
        chk("reset io_out",  64'(bus.io_out),    64'h0);
        chk("reset owner",   64'(bus.owner_o),   64'h0);
        chk("reset busy",    64'(bus.busy_o),    64'h0);
        chk("reset preempt", 64'(bus.preempt_o), 64'h0);

        // Single request on lane 2; other lanes carry decoy values.
        bus.lane_out_i = {8'h77, 8'hA5, 8'h55, 8'h11};
        bus.lane_oeb_i = {8'h0F, 8'h00, 8'hF0, 8'h0F};
        bus.req_i = 4'b0100;
        tick(1);
        chk("single gnt",    64'(bus.gnt_o),  64'b0100);
        chk("single owner",  64'(bus.owner_o), 64'd2);
        chk("single io_out", 64'(bus.io_out), 64'hA5);
        chk("single io_oeb", 64'(bus.io_oeb), 64'h00);
        bus.lane_out_i[2*WIDTH +: WIDTH] = 8'h3C;
        bus.lane_oeb_i[2*WIDTH +: WIDTH] = 8'hC3;
        tick(1);
        chk("lag io_out", 64'(bus.io_out), 64'h3C);
        chk("lag io_oeb", 64'(bus.io_oeb), 64'hC3);
        bus.req_i = 4'b0000;
        tick(1);
        chk("drop gnt",      64'(bus.gnt_o),  64'h0);
        chk("turn1 io_oeb",  64'(bus.io_oeb), 64'hFF);
        chk("turn1 busy",    64'(bus.busy_o), 64'h1);
        tick(1);
        chk("turn2 io_oeb",  64'(bus.io_oeb), 64'hFF);
        chk("turn2 busy",    64'(bus.busy_o), 64'h1);
        tick(1);
        chk("idle busy",     64'(bus.busy_o), 64'h0);

        // Round robin with all four requesting.
        do_reset();
        wiggle = 1'b1;
        bus.req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin order[i] = -1; glen[i] = -1; gap[i] = -1; end
        ng = 0; cur_len = 0; cur_gap = 0; npre = 0; prev = '0;
        for (int c = 0; c < 150 && ng < 5; c++) begin
            tick(1);
            if (bus.preempt_o) npre++;
            if (bus.gnt_o != '0) begin
                if (prev == '0) begin
                    if (ng > 0) begin gap[ng] = cur_gap; glen[ng-1] = cur_len; end
                    order[ng] = int'(bus.owner_o);
                    ng++;
                    cur_len = 0;
                    cur_gap = 0;
                end
                cur_len++;
            end else if (bus.busy_o) begin
                cur_gap++;
            end
            prev = bus.gnt_o;
        end
        chk("rr grant count", 64'(ng), 64'd5);
        for (int i = 0; i < 5; i++) chk("rr order", 64'(order[i]), 64'(i % NREQ));
        for (int i = 0; i < 4; i++) chk("rr hold len", 64'(glen[i]), 64'd8);
        for (int i = 1; i < 5; i++) chk("rr turn gap", 64'(gap[i]), 64'd2);
        chk("rr preempts", 64'(npre), 64'd4);

        // Release in the same cycle as the hold timeout.
        do_reset();
        bus.req_i = 4'b0011;
        wait_gnt("sim grant0", 4);
        chk("sim owner0", 64'(bus.gnt_o), 64'b0001);
        tick(MAX_HOLD - 1);
        bus.req_i = 4'b0010;
        tick(1);
        chk("sim preempt", 64'(bus.preempt_o), 64'h0);
        chk("sim gnt off", 64'(bus.gnt_o), 64'h0);
        wait_gnt("sim grant1", 6);
        chk("sim next owner", 64'(bus.gnt_o), 64'b0010);

        // One low cycle of req is enough to release.
        tick(2);
        bus.req_i = 4'b0000;
        tick(1);
        bus.req_i = 4'b0010;
        chk("glitch release", 64'(bus.gnt_o), 64'h0);
        chk("glitch preempt", 64'(bus.preempt_o), 64'h0);
        tick(6);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        bus.req_i = 4'b0100;
        wait_gnt("rst grant", 4);
        tick(2);
        #2 wb_rst_i = 1'b0;
        #1;
        chk("async rst gnt",    64'(bus.gnt_o),  64'h0);
        chk("async rst io_oeb", 64'(bus.io_oeb), 64'hFF);
        chk("async rst io_out", 64'(bus.io_out), 64'h0);
        chk("async rst busy",   64'(bus.busy_o), 64'h0);
        bus.req_i = 4'b0001;
        tick(1);
        wb_rst_i = 1'b1;
        wait_gnt("post rst grant", 4);
        chk("post rst gnt", 64'(bus.gnt_o), 64'b0001);

`ifdef IO_ARB_LOCK_EN
        do_reset();
        bus.req_i = 4'b0011;
        wait_gnt("lock grant", 4);
        tick(MAX_HOLD - 1);
        lock = 1'b1;
        npre = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (bus.preempt_o) npre++;
        end
        chk("lock held gnt",  64'(bus.gnt_o), 64'b0001);
        chk("lock preempts",  64'(npre), 64'd0);
        lock = 1'b0;
        tick(1);
        chk("unlock gnt",     64'(bus.gnt_o), 64'h0);
        chk("unlock preempt", 64'(bus.preempt_o), 64'h1);
`endif

        tick(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
